// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and the memory arbiter state type.
// The sync generator and the arbiter both take their active-area sizes from here.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOST  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port frame memory between the per-line pixel fetch into an
// external line buffer and a host port; the host gets one slot per BURST fetch words.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int BURST    = 16
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [9:0]        line_y,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [9:0]        lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              underrun,
    input  logic              clr_underrun,
    output arb_state_e        dbg_state
);

    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [CW-1:0] CNT_END   = CW'(H_ACTIVE);
    localparam logic [BW-1:0] BURST_END = BW'(BURST);

    arb_state_e        state, state_n;
    logic              fetch_pend, pend_n, pend_acked;
    logic [ADDR_W-1:0] base, base_n, line_base;
    logic [CW-1:0]     count, count_n, count_acked;
    logic [BW-1:0]     burst_cnt, burst_n, burst_acked;
    logic              stale, stale_n;
    logic              ls_load, fetch_ack, host_ack, fetch_write, free_slot, host_ok;
    logic              mem_req_n, mem_we_n, host_gnt_n, lb_we_n, underrun_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, host_rdata_n, lb_wdata_n;
    logic [9:0]        lb_waddr_n;

    assign line_base = ADDR_W'(line_y) * ADDR_W'(H_ACTIVE);
    assign dbg_state = state;

    // Memory handshake: mem_req plus command are held from issue through the
    // cycle mem_ack is high; a new command may be presented right after that edge.
    always_comb begin
        ls_load     = line_start && (32'(line_y) < 32'(V_ACTIVE));
        fetch_ack   = (state == ST_FETCH) && mem_ack;
        host_ack    = (state == ST_HOST) && mem_ack;
        fetch_write = fetch_ack && !stale && (count < CNT_END);
        free_slot   = (state == ST_IDLE) || mem_ack;
        // host_req is still high while the grant of its own access is in flight
        host_ok     = host_req && !host_ack && !host_gnt;

        count_acked = fetch_write ? count + CW'(1) : count;
        pend_acked  = fetch_pend && !(fetch_write && (count + CW'(1) == CNT_END));
        burst_acked = burst_cnt;
        if (fetch_write && (burst_cnt != BURST_END))
            burst_acked = burst_cnt + BW'(1);

        base_n  = base;
        count_n = count_acked;
        pend_n  = pend_acked;
        burst_n = burst_acked;
        if (ls_load) begin
            base_n  = line_base;
            count_n = '0;
            pend_n  = 1'b1;
            burst_n = '0;
        end

        underrun_n = underrun;
        if (ls_load && pend_acked)
            underrun_n = 1'b1;
        else if (clr_underrun)
            underrun_n = 1'b0;

        // An access still outstanding when its line is abandoned must not write.
        stale_n = stale;
        if (fetch_ack)
            stale_n = 1'b0;
        else if (ls_load && (state == ST_FETCH))
            stale_n = 1'b1;

        lb_we_n    = fetch_write;
        lb_waddr_n = lb_waddr;
        lb_wdata_n = lb_wdata;
        if (fetch_write) begin
            lb_waddr_n = 10'(count);
            lb_wdata_n = mem_rdata;
        end

        host_gnt_n   = host_ack;
        host_rdata_n = host_rdata;
        if (host_ack && !mem_we)
            host_rdata_n = mem_rdata;

        state_n     = state;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if (free_slot) begin
            state_n   = ST_IDLE;
            mem_req_n = 1'b0;
            mem_we_n  = 1'b0;
            if (pend_n && !(host_ok && (burst_n == BURST_END))) begin
                state_n     = ST_FETCH;
                mem_req_n   = 1'b1;
                mem_addr_n  = base_n + ADDR_W'(count_n);
                mem_wdata_n = '0;
            end else if (host_ok) begin
                state_n     = ST_HOST;
                mem_req_n   = 1'b1;
                mem_we_n    = host_we;
                mem_addr_n  = host_addr;
                mem_wdata_n = host_wdata;
                burst_n     = '0;
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            fetch_pend <= 1'b0;
            base       <= '0;
            count      <= '0;
            burst_cnt  <= '0;
            stale      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            host_gnt   <= 1'b0;
            host_rdata <= '0;
            lb_we      <= 1'b0;
            lb_waddr   <= '0;
            lb_wdata   <= '0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pend <= pend_n;
            base       <= base_n;
            count      <= count_n;
            burst_cnt  <= burst_n;
            stale      <= stale_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            host_gnt   <= host_gnt_n;
            host_rdata <= host_rdata_n;
            lb_we      <= lb_we_n;
            lb_waddr   <= lb_waddr_n;
            lb_wdata   <= lb_wdata_n;
            underrun   <= underrun_n;
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: behavioural frame memory, line-buffer and host
// scoreboards, directed line/host scenarios followed by a randomized phase.
module tb_vga_mem_arbiter;
    import vga_pkg::*;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;
    localparam int BURST    = 16;

    logic              vga_clk, reset, line_start, host_req, host_we;
    logic [9:0]        line_y;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata, mem_wdata, mem_rdata, lb_wdata;
    logic              host_gnt, mem_req, mem_we, mem_ack, lb_we, underrun, clr_underrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [9:0]        lb_waddr;
    arb_state_e        dbg_state;

    vga_mem_arbiter #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .BURST(BURST)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .line_start(line_start), .line_y(line_y),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_waddr(lb_waddr),
        .lb_wdata(lb_wdata), .underrun(underrun), .clr_underrun(clr_underrun),
        .dbg_state(dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [17:0] exp_q[$];
    logic [8:0]  host_q[$];
    logic [7:0]  ref_mem[int];
    logic [7:0]  dev_mem[int];

    int lat_lo = 0, lat_hi = 0;
    bit inject_ack = 0;
    bit arm_first = 0;
    int first_addr = -1;
    int watch_addr = -1, after_watch = -1;
    bit watch_hit = 0;

    bit free_mode = 0;
    int free_base = 0, free_idx = 0;
    int lb_total = 0, line_words = 0, lb_at_gnt = -1, host_wait = 0;

    // clock / reset
    initial begin
        vga_clk = 0;
        forever #5 vga_clk = ~vga_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        logic [31:0] u;
        u = a;
        return u[7:0] ^ u[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_val(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    // behavioural single-port memory with per-access latency
    initial begin
        int wcnt, cur_lat, a;
        logic [27:0] cmd;
        mem_ack = 0; mem_rdata = 0; wcnt = 0; cur_lat = 0; cmd = '0;
        forever begin
            @(negedge vga_clk);
            mem_ack = 0;
            if (inject_ack) begin
                mem_ack = 1; mem_rdata = 8'h3C; inject_ack = 0;
            end else if (reset || !mem_req) begin
                wcnt = 0;
            end else begin
                if (wcnt == 0) cmd = {mem_we, mem_wdata, mem_addr};
                else chk("mem_cmd_stable", {mem_we, mem_wdata, mem_addr}, cmd);
                if (wcnt >= cur_lat) begin
                    a = int'(mem_addr);
                    mem_ack = 1;
                    if (mem_we) dev_mem[a] = mem_wdata;
                    else begin
                        mem_rdata = dev_mem.exists(a) ? dev_mem[a] : init_val(a);
                        if (arm_first) begin first_addr = a; arm_first = 0; end
                        if (watch_hit) begin after_watch = a; watch_hit = 0; end
                    end
                    if (a == watch_addr) watch_hit = 1;
                    wcnt = 0;
                    cur_lat = $urandom_range(lat_hi, lat_lo);
                end else wcnt++;
            end
        end
    end

    // monitor: line buffer writes and host grants
    initial begin
        logic [17:0] e;
        logic [8:0]  h;
        forever begin
            @(posedge vga_clk); #1;
            if (reset) continue;
            if (lb_we) begin
                lb_total++; line_words++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("lb_write", {lb_waddr, lb_wdata}, e);
                end else if (free_mode) begin
                    chk("lb_free_waddr", lb_waddr, free_idx);
                    chk("lb_free_data", lb_wdata, ref_val(free_base + free_idx));
                    free_idx++;
                end else chk("lb_unexpected", lb_we, 0);
            end
            if (line_start && line_y < V_ACTIVE) begin
                free_base = int'(line_y) * H_ACTIVE; free_idx = 0; line_words = 0;
            end
            if (host_gnt) begin
                lb_at_gnt = line_words;
                chk("host_wait_bound", host_wait <= BURST, 1);
                host_wait = 0;
                if (host_q.size() == 0) chk("host_gnt_unrequested", host_gnt, 0);
                else begin
                    h = host_q.pop_front();
                    if (h[8]) chk("host_rdata", host_rdata, h[7:0]);
                end
            end else if (host_req) host_wait += lb_we;
            else host_wait = 0;
        end
    end

    // driver tasks
    task automatic do_line(input int y, input bit push);
        @(negedge vga_clk);
        line_start = 1; line_y = 10'(y);
        if (push && y < V_ACTIVE)
            for (int i = 0; i < H_ACTIVE; i++)
                exp_q.push_back({10'(i), ref_val(y * H_ACTIVE + i)});
        @(negedge vga_clk);
        line_start = 0;
    endtask

    task automatic host_access(input bit we, input int addr, input logic [7:0] wd);
        bit got;
        @(negedge vga_clk);
        host_req = 1; host_we = we; host_addr = ADDR_W'(addr); host_wdata = wd;
        if (we) begin ref_mem[addr] = wd; host_q.push_back({1'b0, wd}); end
        else host_q.push_back({1'b1, ref_val(addr)});
        got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge vga_clk);
            if (host_gnt) got = 1;
        end
        chk("host_gnt_seen", got, 1);
        host_req = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < budget) begin @(negedge vga_clk); i++; end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int req_cycles, lb_before, i, y;
        reset = 1; line_start = 0; line_y = 0; host_req = 0; host_we = 0;
        host_addr = 0; host_wdata = 0; clr_underrun = 0;
        repeat (3) @(negedge vga_clk);
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_host_gnt", host_gnt, 0); chk("rst_host_rdata", host_rdata, 0);
        chk("rst_lb_we", lb_we, 0);       chk("rst_lb_waddr", lb_waddr, 0);
        chk("rst_lb_wdata", lb_wdata, 0); chk("rst_underrun", underrun, 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 0;
        repeat (2) @(negedge vga_clk);

        // full line 0, ack every cycle
        arm_first = 1;
        do_line(0, 1);
        wait_drain("line0_done", 2000);
        repeat (4) @(negedge vga_clk);
        chk("line0_first_addr", first_addr, 0);
        chk("line0_words", line_words, H_ACTIVE);
        chk("line0_underrun", underrun, 0);

        // last visible line and first invisible line
        arm_first = 1;
        do_line(479, 1);
        wait_drain("line479_done", 2000);
        chk("line479_first_addr", first_addr, 306560);
        do_line(480, 1);
        req_cycles = 0;
        repeat (100) begin @(negedge vga_clk); if (mem_req) req_cycles++; end
        chk("line480_no_req", req_cycles, 0);
        chk("line480_idle", 32'(dbg_state), 32'(ST_IDLE));

        // idle host write then read back
        host_access(1, 1000, 8'hA5);
        host_access(0, 1000, 8'h00);
        chk("host_q_empty_idle", host_q.size(), 0);

        // host request held from line start: served at the burst boundary
        watch_addr = 400000; after_watch = -1;
        fork
            do_line(10, 1);
            host_access(0, 400000, 8'h00);
        join
        wait_drain("line10_done", 3000);
        chk("burst_gnt_after_words", lb_at_gnt, BURST);
        chk("burst_resume_addr", after_watch, 10 * H_ACTIVE + BURST);
        watch_addr = -1;

        // slow memory: underrun, clear, and set-beats-clear
        lat_lo = 3; lat_hi = 3; free_mode = 1;
        do_line(5, 0);
        repeat (798) @(negedge vga_clk);
        do_line(6, 0);
        chk("underrun_set", underrun, 1);
        @(negedge vga_clk); clr_underrun = 1;
        @(negedge vga_clk); clr_underrun = 0;
        chk("underrun_clr", underrun, 0);
        @(negedge vga_clk);
        line_start = 1; line_y = 10'd7; clr_underrun = 1;
        @(negedge vga_clk);
        line_start = 0; clr_underrun = 0;
        chk("underrun_set_wins", underrun, 1);
        lat_lo = 0; lat_hi = 0;
        i = 0;
        while (free_idx < H_ACTIVE && i < 4000) begin @(negedge vga_clk); i++; end
        repeat (4) @(negedge vga_clk);
        chk("line7_words", free_idx, H_ACTIVE);

        // reset in the middle of a fetch access
        lat_lo = 3; lat_hi = 3;
        do_line(20, 0);
        repeat (10) @(negedge vga_clk);
        i = 0;
        while (!mem_req && i < 20) begin @(negedge vga_clk); i++; end
        chk("mid_fetch_req", mem_req, 1);
        reset = 1;
        #1;
        chk("reset_drops_req", mem_req, 0);
        @(posedge vga_clk); #1;
        chk("reset_lb_we", lb_we, 0);       chk("reset_underrun", underrun, 0);
        chk("reset_mem_addr", mem_addr, 0); chk("reset_host_gnt", host_gnt, 0);
        chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        lb_before = lb_total;
        @(negedge vga_clk);
        reset = 0; free_mode = 0; inject_ack = 1;
        req_cycles = 0;
        repeat (20) begin @(negedge vga_clk); if (mem_req) req_cycles++; end
        chk("late_ack_no_lb", lb_total, lb_before);
        chk("late_ack_no_req", req_cycles, 0);

        // randomized lines with concurrent random host traffic
        lat_lo = 0; lat_hi = 1;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    y = $urandom_range(V_ACTIVE - 1, 0);
                    do_line(y, 1);
                    wait_drain("rand_line_done", 4000);
                    repeat ($urandom_range(50, 5)) @(negedge vga_clk);
                end
            end
            begin
                for (int n = 0; n < 12; n++) begin
                    repeat ($urandom_range(200, 20)) @(negedge vga_clk);
                    host_access(1'($urandom_range(1, 0)), 400000 + $urandom_range(15, 0),
                                8'($urandom));
                end
            end
        join
        repeat (10) @(negedge vga_clk);
        chk("rand_underrun", underrun, 0);
        chk("final_host_q", host_q.size(), 0);
        chk("final_lb_q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
